// File: rtl/tt_sweep_if.sv
// Stream and control bundle for the truth-table sweep engine.
// master = controller/consumer side, slave = the sweep engine.
interface tt_sweep_if #(
  parameter int N = 3
);
  logic         start;
  logic         gray_mode;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] out_vec;
  logic         out_x;
  logic         out_y;
  logic         busy;
  logic         done;
  logic [N:0]   x_count;
  logic [N:0]   y_count;
  logic [N:0]   diff_count;
  logic [1:0]   state_dbg;

  modport master (
    output start, gray_mode, out_ready,
    input  out_valid, out_vec, out_x, out_y, busy, done,
    input  x_count, y_count, diff_count, state_dbg
  );

  modport slave (
    input  start, gray_mode, out_ready,
    output out_valid, out_vec, out_x, out_y, busy, done,
    output x_count, y_count, diff_count, state_dbg
  );
endinterface

// File: rtl/tt_sweep_eval.sv
// Steps an N-bit vector through all 2^N values (binary or Gray order) and
// streams x/y truth-table lookups with per-sweep hit and difference counts.
module tt_sweep_eval #(
  parameter int                N    = 3,
  parameter logic [(1<<N)-1:0] X_TT = 8'hEE,
  parameter logic [(1<<N)-1:0] Y_TT = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  tt_sweep_if.slave  bus
);
  localparam int CW = N + 1;

  // Handshake: a beat transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low the
  // beat (out_vec/out_x/out_y) holds stable. out_ready is ignored otherwise.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [N-1:0]  vec_q, vec_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] xc_q, xc_d;
  logic [CW-1:0] yc_q, yc_d;
  logic [CW-1:0] dc_q, dc_d;
  logic [N-1:0]  idx_inc;
  logic          accept;

  assign idx_inc = idx_q + N'(1);
  assign accept  = (state_q == S_RUN) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      mode_q  <= 1'b0;
      xc_q    <= '0;
      yc_q    <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      mode_q  <= mode_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      dc_q    <= dc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    mode_d  = mode_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    dc_d    = dc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          idx_d   = '0;
          vec_d   = '0;
          mode_d  = bus.gray_mode;
          xc_d    = '0;
          yc_d    = '0;
          dc_d    = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (bus.out_x)              xc_d = xc_q + CW'(1);
          if (bus.out_y)              yc_d = yc_q + CW'(1);
          if (bus.out_x != bus.out_y) dc_d = dc_q + CW'(1);
          if (idx_q == {N{1'b1}}) begin
            state_d = S_DONE;
          end else begin
            // Vector is registered, so compute the next index's mapping now.
            idx_d = idx_inc;
            vec_d = mode_q ? (idx_inc ^ (idx_inc >> 1)) : idx_inc;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.out_valid  = (state_q == S_RUN);
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.out_vec    = vec_q;
  assign bus.out_x      = X_TT[vec_q];
  assign bus.out_y      = Y_TT[vec_q];
  assign bus.x_count    = xc_q;
  assign bus.y_count    = yc_q;
  assign bus.diff_count = dc_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_tt_sweep_eval.sv
// Directed bench for tt_sweep_eval: three instances cover default tables,
// odd-parity/Gray order, and the N=1 width corner.
module tb_tt_sweep_eval;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   beat;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Hand-written expected sequences.
  int exp_x_ee [8] = '{0, 1, 1, 1, 0, 1, 1, 1};
  int exp_gray [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int exp_x_par[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  tt_sweep_if #(.N(3)) a_if ();
  tt_sweep_if #(.N(3)) b_if ();
  tt_sweep_if #(.N(1)) c_if ();

  tt_sweep_eval #(.N(3), .X_TT(8'hEE), .Y_TT(8'hEE)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  tt_sweep_eval #(.N(3), .X_TT(8'h96), .Y_TT(8'h00)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  tt_sweep_eval #(.N(1), .X_TT(2'b10), .Y_TT(2'b11)) u_c (.clk(clk), .rst(rst), .bus(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    a_if.start = 1'b0; a_if.gray_mode = 1'b0; a_if.out_ready = 1'b0;
    b_if.start = 1'b0; b_if.gray_mode = 1'b0; b_if.out_ready = 1'b0;
    c_if.start = 1'b0; c_if.gray_mode = 1'b0; c_if.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset values
    chk("rst_a_valid", a_if.out_valid, 0);
    chk("rst_a_vec",   a_if.out_vec,   0);
    chk("rst_a_x",     a_if.out_x,     0);
    chk("rst_a_busy",  a_if.busy,      0);
    chk("rst_a_done",  a_if.done,      0);
    chk("rst_a_xc",    a_if.x_count,   0);
    chk("rst_a_state", a_if.state_dbg, ST_IDLE);
    chk("rst_c_x",     c_if.out_x,     0);
    chk("rst_c_y",     c_if.out_y,     1);
    chk("rst_c_dc",    c_if.diff_count, 0);

    // Binary sweep, default tables, no back-pressure
    a_if.out_ready = 1'b1;
    a_if.start     = 1'b1;
    step();
    a_if.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("bin_valid", a_if.out_valid, 1);
      chk("bin_busy",  a_if.busy,      1);
      chk("bin_vec",   a_if.out_vec,   i);
      chk("bin_x",     a_if.out_x,     exp_x_ee[i]);
      chk("bin_y",     a_if.out_y,     exp_x_ee[i]);
      step();
    end
    chk("bin_done",    a_if.done,      1);
    chk("bin_dvalid",  a_if.out_valid, 0);
    chk("bin_dbusy",   a_if.busy,      0);
    chk("bin_xc",      a_if.x_count,   6);
    chk("bin_yc",      a_if.y_count,   6);
    chk("bin_dc",      a_if.diff_count, 0);
    step();
    chk("bin_done_pulse", a_if.done,   0);
    chk("bin_idle",    a_if.state_dbg, ST_IDLE);
    chk("bin_hold_vec", a_if.out_vec,  7);
    chk("bin_hold_xc", a_if.x_count,   6);

    // Gray sweep, odd parity x, zero y
    b_if.out_ready = 1'b1;
    b_if.gray_mode = 1'b1;
    b_if.start     = 1'b1;
    step();
    b_if.start     = 1'b0;
    b_if.gray_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("gray_vec", b_if.out_vec, exp_gray[i]);
      chk("gray_x",   b_if.out_x,   exp_x_par[i]);
      chk("gray_y",   b_if.out_y,   0);
      step();
    end
    chk("gray_done", b_if.done,       1);
    chk("gray_xc",   b_if.x_count,    4);
    chk("gray_yc",   b_if.y_count,    0);
    chk("gray_dc",   b_if.diff_count, 4);
    step();

    // Back-pressure: ready only on every other cycle
    a_if.out_ready = 1'b0;
    a_if.start     = 1'b1;
    step();
    a_if.start = 1'b0;
    cyc  = 0;
    beat = 0;
    while (a_if.out_valid === 1'b1 && cyc < 40) begin
      chk("bp_vec", a_if.out_vec, beat);
      chk("bp_x",   a_if.out_x,   exp_x_ee[beat % 8]);
      a_if.out_ready = (cyc % 2) == 1;
      step();
      if ((cyc % 2) == 1) beat++;
      cyc++;
    end
    chk("bp_valid_cycles", cyc,  16);
    chk("bp_beats",        beat, 8);
    chk("bp_done",   a_if.done,       1);
    chk("bp_xc",     a_if.x_count,    6);
    chk("bp_yc",     a_if.y_count,    6);
    chk("bp_dc",     a_if.diff_count, 0);
    a_if.out_ready = 1'b1;
    step();

    // start pulsed during RUN (at vec 3) and during DONE is ignored
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("ign_vec", a_if.out_vec, i);
      a_if.start = (i == 3);
      step();
    end
    chk("ign_done", a_if.done, 1);
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    chk("ign_done_once", a_if.done,      0);
    chk("ign_valid",     a_if.out_valid, 0);
    chk("ign_state",     a_if.state_dbg, ST_IDLE);
    chk("ign_xc",        a_if.x_count,   6);
    step();
    chk("ign_no_restart", a_if.out_valid, 0);

    // rst together with start mid-sweep at vec 5
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rs_vec", a_if.out_vec, i);
      step();
    end
    chk("rs_vec5",  a_if.out_vec,   5);
    chk("rs_state", a_if.state_dbg, ST_RUN);
    rst        = 1'b1;
    a_if.start = 1'b1;
    step();
    rst        = 1'b0;
    a_if.start = 1'b0;
    chk("rs_valid", a_if.out_valid,  0);
    chk("rs_busy",  a_if.busy,       0);
    chk("rs_xc",    a_if.x_count,    0);
    chk("rs_yc",    a_if.y_count,    0);
    chk("rs_dc",    a_if.diff_count, 0);
    chk("rs_idle",  a_if.state_dbg,  ST_IDLE);
    step();
    chk("rs_still_idle", a_if.out_valid, 0);
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rs2_vec", a_if.out_vec, i);
      step();
    end
    chk("rs2_done", a_if.done,    1);
    chk("rs2_xc",   a_if.x_count, 6);
    step();

    // N=1 corner: two beats, 2-bit counts reach 2 without wrap
    c_if.out_ready = 1'b1;
    c_if.start     = 1'b1;
    step();
    c_if.start = 1'b0;
    chk("n1_vec0", c_if.out_vec, 0);
    chk("n1_x0",   c_if.out_x,   0);
    chk("n1_y0",   c_if.out_y,   1);
    step();
    chk("n1_vec1", c_if.out_vec, 1);
    chk("n1_x1",   c_if.out_x,   1);
    chk("n1_y1",   c_if.out_y,   1);
    step();
    chk("n1_done", c_if.done,       1);
    chk("n1_xc",   c_if.x_count,    1);
    chk("n1_yc",   c_if.y_count,    2);
    chk("n1_dc",   c_if.diff_count, 1);
    step();
    chk("n1_idle", c_if.state_dbg, ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tt_sweep_eval.md
# tt_sweep_eval

Parametrised truth-table sweep-and-evaluate engine. On a start pulse it steps an N-bit input vector through all 2^N combinations, in binary or Gray order, and evaluates two configurable boolean functions, x and y, on each vector. It presents each result through a registered valid/ready stream and accumulates per-sweep statistics. It sits between the team's boolean-function exercisers and downstream checkers/loggers, replacing fixed-arity, purely combinational evaluation with a self-sequencing, back-pressurable source.

## Interface
- N, default 3: number of function inputs; legal range 1..8.
- X_TT, default 8'hEE: truth table for x, 2^N bits; bit i = x(vec==i).
- Y_TT, default 8'hEE: truth table for y, 2^N bits; bit i = y(vec==i).
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- gray_mode  input  1  0 = binary order, 1 = Gray order; sampled with start.
- out_ready  input  1  downstream accepts the current beat.
- out_valid  output  1  beat on out_vec/out_x/out_y is valid.
- out_vec  output  N  input combination for this beat (bit 0 = first input).
- out_x  output  1  X_TT[out_vec].
- out_y  output  1  Y_TT[out_vec].
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the last beat is accepted.
- x_count  output  N+1  accepted beats with out_x=1 in the current/last sweep.
- y_count  output  N+1  accepted beats with out_y=1.
- diff_count  output  N+1  accepted beats with out_x != out_y.

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 moves to RUN.
  - On the same edge: index := 0, the three counts := 0, mode := gray_mode.
  - start is ignored in RUN and DONE.
- RUN:
  - out_valid=1.
  - out_vec = index (binary mode) or index ^ (index >> 1) (Gray mode).
  - out_x and out_y are looked up from out_vec, not from index.
- Accept (out_valid & out_ready):
  - Counts increment per their conditions.
  - If index == 2^N-1: move to DONE.
  - Otherwise: index := index+1.
- No accept: out_vec, out_x and out_y hold stable; no count changes.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Counts hold their final values in IDLE until the next honoured start or rst.
- Counts are N+1 bits wide, so an all-ones table yields exactly 2^N with no wrap.
- Index is N bits; the terminal compare is on the full N-bit value.
- rst:
  - State goes to IDLE from any state, including mid-sweep.
  - index, mode and all counts go to 0.
  - Any in-flight beat is discarded.
  - rst wins over a simultaneous start.

## Timing
- Reset values: out_valid=0, out_vec=0, out_x=X_TT[0], out_y=Y_TT[0], busy=0, done=0, all counts=0.
- out_vec/out_x/out_y are registered; out_x/out_y are combinational lookups of registered out_vec. In IDLE/DONE they show the last driven vector.
- start sampled high in IDLE at edge k: out_valid=1, busy=1, out_vec=0 from cycle k+1.
- Zero back-pressure: one beat per cycle. A full sweep is 2^N cycles of out_valid, then one cycle of done.
- Last accept at edge m:
  - out_valid=0, busy=0, done=1 during cycle m+1.
  - IDLE from m+2.
  - The earliest new start is sampled at edge m+2.
- Counts reflect an accepted beat on the edge following the accept.
- out_ready has no effect when out_valid=0.

## Test plan
- Reset, then start with N=3, default tables, gray_mode=0, out_ready=1:
  - out_vec = 0..7 on consecutive cycles.
  - out_x = 0,1,1,1,0,1,1,1.
  - done one cycle after vec 7.
  - x_count=6, y_count=6, diff_count=0.
- gray_mode=1, X_TT=8'h96 (odd parity), Y_TT=8'h00:
  - out_vec = 0,1,3,2,6,7,5,4.
  - out_x alternates 0,1,0,1,…
  - x_count=4, diff_count=4.
- Back-pressure: out_ready low on every other cycle:
  - Each vec holds until accepted.
  - Total 16 valid cycles for 8 beats.
  - Counts identical to the first case.
- start pulsed during RUN at vec 3 and during DONE: ignored; sweep completes normally with one done pulse.
- rst asserted at vec 5 together with start:
  - Next cycle out_valid=0, busy=0, counts=0, state IDLE.
  - A later start sweeps from vec 0.
- N=1, X_TT=2'b10, Y_TT=2'b11:
  - Two beats, vec 0 then 1.
  - x_count=1, y_count=2, diff_count=1 (width 2, no overflow).
